// File: rtl/flag_reg_bank.sv
// flag_reg_bank: WIDTH synchronised status flags with edge/level capture.
// Optional IRQ output is built when FLAG_REG_BANK_IRQ_EN is defined.
module flag_reg_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_MODE   = 1,
  parameter bit               STICKY      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] set_mask,
  input  logic [WIDTH-1:0] clr_mask,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] evt,
  output logic             any_q
`ifdef FLAG_REG_BANK_IRQ_EN
  ,
  input  logic [WIDTH-1:0] irq_mask,
  output logic             irq
`endif
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] evt_q;
  logic             any_flag_q;

  assign s_last = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_MODE == 0) begin : g_level
      assign e = s_last;
    end else if (EDGE_MODE == 1) begin : g_rise
      assign e = s_last & ~prev_q;
    end else if (EDGE_MODE == 2) begin : g_fall
      assign e = ~s_last & prev_q;
    end else begin : g_both
      assign e = s_last ^ prev_q;
    end
  endgenerate

  // Set beats clear beats load beats event capture.
  assign base = ld_en ? ld_data
              : (STICKY ? (q_q | e) : e);
  assign q_d  = set_mask | (~clr_mask & base);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++)
        sync_q[k] <= '0;
      prev_q     <= '0;
      q_q        <= RESET_VAL;
      evt_q      <= '0;
      any_flag_q <= |RESET_VAL;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < int'(SYNC_STAGES); k++)
        sync_q[k] <= sync_q[k-1];
      prev_q     <= s_last;
      q_q        <= q_d;
      evt_q      <= e;
      any_flag_q <= |q_d;
    end
  end

  assign q     = q_q;
  assign evt   = evt_q;
  assign any_q = any_flag_q;

`ifdef FLAG_REG_BANK_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |(q_d & irq_mask);
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_flag_reg_bank.sv
// tb_flag_reg_bank: four flag_reg_bank configurations checked against
// a sample-history reference model plus directed boundary checks.
module tb_flag_reg_bank;

  localparam int N = 4;
  localparam int MODE [N] = '{1, 3, 2, 0};
  localparam int SS   [N] = '{2, 2, 3, 1};
  localparam bit STK  [N] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [7:0] RV [N] = '{8'hA5, 8'h00, 8'h00, 8'h3C};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din, set_mask, clr_mask, ld_data, irq_mask;
  logic       ld_en;
  logic [7:0] q_w   [N];
  logic [7:0] evt_w [N];
  logic       any_w [N];
  logic       irq_w [N];

  logic [7:0] hist [N][6];
  logic [7:0] mq   [N];
  logic [7:0] mevt [N];
  logic       many [N];
  logic       mirq [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flag_reg_bank #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1),
    .STICKY(1'b1), .RESET_VAL(8'hA5)
  ) u_a (
    .clk(clk), .reset(reset), .din(din),
    .set_mask(set_mask), .clr_mask(clr_mask),
    .ld_en(ld_en), .ld_data(ld_data),
    .q(q_w[0]), .evt(evt_w[0]), .any_q(any_w[0])
`ifdef FLAG_REG_BANK_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq_w[0])
`endif
  );

  flag_reg_bank #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(3),
    .STICKY(1'b0), .RESET_VAL(8'h00)
  ) u_b (
    .clk(clk), .reset(reset), .din(din),
    .set_mask(set_mask), .clr_mask(clr_mask),
    .ld_en(ld_en), .ld_data(ld_data),
    .q(q_w[1]), .evt(evt_w[1]), .any_q(any_w[1])
`ifdef FLAG_REG_BANK_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq_w[1])
`endif
  );

  flag_reg_bank #(
    .WIDTH(8), .SYNC_STAGES(3), .EDGE_MODE(2),
    .STICKY(1'b1), .RESET_VAL(8'h00)
  ) u_c (
    .clk(clk), .reset(reset), .din(din),
    .set_mask(set_mask), .clr_mask(clr_mask),
    .ld_en(ld_en), .ld_data(ld_data),
    .q(q_w[2]), .evt(evt_w[2]), .any_q(any_w[2])
`ifdef FLAG_REG_BANK_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq_w[2])
`endif
  );

  flag_reg_bank #(
    .WIDTH(8), .SYNC_STAGES(1), .EDGE_MODE(0),
    .STICKY(1'b0), .RESET_VAL(8'h3C)
  ) u_d (
    .clk(clk), .reset(reset), .din(din),
    .set_mask(set_mask), .clr_mask(clr_mask),
    .ld_en(ld_en), .ld_data(ld_data),
    .q(q_w[3]), .evt(evt_w[3]), .any_q(any_w[3])
`ifdef FLAG_REG_BANK_IRQ_EN
    , .irq_mask(irq_mask), .irq(irq_w[3])
`endif
  );

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h",
             tag, idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 6; k++) hist[i][k] = '0;
      mq[i]   = RV[i];
      mevt[i] = '0;
      many[i] = (RV[i] != 0);
      mirq[i] = 1'b0;
    end
  endtask

  // hist[i][k] holds the din sample taken k+1 edges ago.
  task automatic model_edge();
    logic [7:0] cur, old, e, qn;
    for (int i = 0; i < N; i++) begin
      cur = hist[i][SS[i]-1];
      old = hist[i][SS[i]];
      case (MODE[i])
        0:       e = cur;
        1:       e = cur & ~old;
        2:       e = ~cur & old;
        default: e = cur ^ old;
      endcase
      for (int b = 0; b < 8; b++) begin
        if (set_mask[b])      qn[b] = 1'b1;
        else if (clr_mask[b]) qn[b] = 1'b0;
        else if (ld_en)       qn[b] = ld_data[b];
        else if (STK[i])      qn[b] = mq[i][b] | e[b];
        else                  qn[b] = e[b];
      end
      mevt[i] = e;
      mq[i]   = qn;
      many[i] = (qn != 0);
      mirq[i] = ((qn & irq_mask) != 0);
      for (int k = 5; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = din;
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < N; i++) begin
      chk("q", i, q_w[i], mq[i]);
      chk("evt", i, evt_w[i], mevt[i]);
      chk("any_q", i, any_w[i], many[i]);
`ifdef FLAG_REG_BANK_IRQ_EN
      chk("irq", i, irq_w[i], mirq[i]);
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    model_reset();
    cmp_all();
  endtask

  task automatic quiet();
    set_mask = '0;
    clr_mask = '0;
    ld_en    = 1'b0;
    ld_data  = '0;
  endtask

  initial begin
    int cnt;
    logic [7:0] ev;
    reset = 1'b1;
    din = '0;
    irq_mask = '0;
    quiet();
    #1;
    model_reset();
    cmp_all();
    chk("rst_q", 0, q_w[0], 8'hA5);
    chk("rst_any", 0, any_w[0], 1'b1);
    chk("rst_evt", 0, evt_w[0], 8'h00);
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("hold_q", 0, q_w[0], 8'hA5);

    din = 8'h08;
    step();
    chk("lat_q3_n", 0, q_w[0][3], 1'b0);
    step();
    chk("lat_q3_n1", 0, q_w[0][3], 1'b0);
    step();
    chk("lat_q3", 0, q_w[0][3], 1'b1);
    chk("lat_evt3", 0, evt_w[0][3], 1'b1);
    din = 8'h00;
    step();
    chk("evt3_drop", 0, evt_w[0][3], 1'b0);
    chk("q3_stick", 0, q_w[0][3], 1'b1);
    repeat (3) step();
    chk("q3_hold", 0, q_w[0][3], 1'b1);
    clr_mask = 8'h08;
    step();
    chk("q3_clr", 0, q_w[0][3], 1'b0);

    set_mask = 8'h01;
    clr_mask = 8'h01;
    ld_en    = 1'b1;
    ld_data  = 8'h00;
    step();
    chk("set_wins", 0, q_w[0][0], 1'b1);
    set_mask = 8'h00;
    ld_data  = 8'h01;
    step();
    chk("clr_beats_ld", 0, q_w[0][0], 1'b0);
    quiet();

    repeat (6) step();
    din = 8'h01;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) din = 8'h00;
      step();
      chk("b_evt0", c, evt_w[1][0], (c == 2 || c == 7));
      chk("b_q0", c, q_w[1][0], (c == 2 || c == 7));
    end

    din = 8'hFF;
    assert_reset();
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("c_no_evt", c, evt_w[2], 8'h00);
    end

    din = 8'h00;
    repeat (5) step();
    din = 8'h08;
    step();
    din = 8'h00;
    assert_reset();
    step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("abort_evt", c, evt_w[0], 8'h00);
    end

    din = 8'hFF;
    assert_reset();
    step();
    reset = 1'b0;
    cnt = 0;
    ev = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (evt_w[0] != 0) begin
        cnt++;
        ev = evt_w[0];
      end
    end
    chk("rel_hi_cnt", 0, cnt, 1);
    chk("rel_hi_evt", 0, ev, 8'hFF);

`ifdef FLAG_REG_BANK_IRQ_EN
    irq_mask = 8'h04;
    din = 8'h00;
    repeat (4) step();
    clr_mask = 8'hFF;
    step();
    clr_mask = 8'h00;
    din = 8'h04;
    step();
    step();
    chk("irq_pre", 0, irq_w[0], 1'b0);
    step();
    chk("irq_q2", 0, q_w[0][2], 1'b1);
    chk("irq_set", 0, irq_w[0], 1'b1);
    clr_mask = 8'hFF;
    step();
    clr_mask = 8'h00;
    din = 8'h02;
    repeat (4) step();
    chk("irq_q1", 0, q_w[0][1], 1'b1);
    chk("irq_off", 0, irq_w[0], 1'b0);
`endif

    for (int c = 0; c < 400; c++) begin
      din      = 8'($urandom);
      set_mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      clr_mask = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      ld_en    = ($urandom_range(0, 9) == 0);
      ld_data  = 8'($urandom);
      irq_mask = 8'($urandom);
      if ($urandom_range(0, 39) == 0) assert_reset();
      else reset = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_reg_bank.md
Name: flag_reg_bank

Overview:
- Parametrised, multi-channel successor to the single-bit set/clear D flip-flop.
- WIDTH independent flag bits, each with:
  - an input synchroniser;
  - a selectable edge/level event detector;
  - sticky or follow capture;
  - synchronous per-bit set, clear and parallel load.
- Used for S-100 bus status/interrupt-source latching and CPU-visible status registers on the T35 SBC fabric.

Parameters:
- WIDTH, 8, number of flag channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (1..4).
- EDGE_MODE, 1, event type: 0 = level high, 1 = rising, 2 = falling, 3 = both edges.
- STICKY, 1, 1 = flag holds until cleared; 0 = flag mirrors the event each cycle.
- RESET_VAL, 0, WIDTH-bit value loaded into q on reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- din  in  WIDTH  raw (asynchronous) channel inputs
- set_mask  in  WIDTH  synchronous per-bit set, active high
- clr_mask  in  WIDTH  synchronous per-bit clear, active high
- ld_en  in  1  parallel load strobe
- ld_data  in  WIDTH  parallel load value
- q  out  WIDTH  flag register
- evt  out  WIDTH  registered one-cycle event pulse per channel
- any_q  out  1  registered OR of q

Behaviour:
- Reset (async assert, takes effect immediately):
  - sync chain = 0, edge-history reg = 0, evt = 0.
  - q = RESET_VAL, any_q = |RESET_VAL.
  - Deassertion is seen at the next clk edge; no other reset timing requirement.
- Synchroniser: s[0] <= din, s[k] <= s[k-1], per bit. prev <= s[SYNC_STAGES-1].
- Event term e, combinational from registers:
  - mode 0: s_last
  - mode 1: s_last & ~prev
  - mode 2: ~s_last & prev
  - mode 3: s_last ^ prev
- Per-bit q update priority, highest first (preset dominates, as in the existing flop):
  1. set_mask -> 1
  2. clr_mask -> 0
  3. ld_en -> ld_data
  4. STICKY=1: q | e
  5. STICKY=0: e
- Simultaneous set and clear on one bit: set wins.
- Simultaneous event and clear: clear wins; the event is lost, but evt still pulses.
- evt <= e every clock regardless of set/clr/ld. Pulse width is exactly one clock per detected event.
- any_q <= |q_next, so it is registered and cycle-aligned with q.
- Latency:
  - Rising mode: a din 0->1 first sampled at edge n gives q=1 and evt=1 after edge n+SYNC_STAGES.
  - evt returns to 0 one edge later.
  - Level/falling/both modes follow the same alignment.
- Reset boundaries:
  - Input already high at reset release: mode 1/3 produce one event SYNC_STAGES edges after release.
  - Mode 2 produces no spurious event.
- Input pulses shorter than one clock may be missed; this is not an error.
- Reset mid-operation aborts any in-flight synchroniser data. There is no pending-event memory.

Optional Feature:
- Macro FLAG_REG_BANK_IRQ_EN.
- When defined, adds:
  - port irq_mask in WIDTH
  - port irq out 1
- irq is registered: irq <= |(q_next & irq_mask). Reset value 0.
- When undefined, neither port exists and there is no IRQ logic. All other behaviour is identical.

Test Plan:
- Reset with RESET_VAL=8'hA5 -> q=A5, any_q=1, evt=00 while reset is high. Release, with din=0 -> values held.
- EDGE_MODE=1, SYNC_STAGES=2, STICKY=1: din[3] 0->1 sampled at edge 10 -> q[3]=1 and evt[3]=1 after edge 12. evt[3]=0 after edge 13. q[3] stays 1 with din[3] low until clr_mask[3] is pulsed -> q[3]=0 next edge.
- set_mask=01, clr_mask=01, ld_en=1, ld_data=00 in the same cycle -> q[0]=1 (set wins). Next cycle clr_mask=01 with ld_en=1, ld_data=01 -> q[0]=0 (clear beats load).
- EDGE_MODE=3, STICKY=0: din[0] high for 5 clocks -> two single-cycle evt[0] pulses 5 clocks apart, q[0] equal to evt[0]. EDGE_MODE=2 with din held high through reset release -> no event.
- Assert reset mid-synchronisation (one edge after din rise) -> no event after release while din stays low. Release with din high in mode 1 -> exactly one event.
- With FLAG_REG_BANK_IRQ_EN: irq_mask=04, event on bit 2 -> irq=1 on the same edge as q[2]. Event on bit 1 only -> irq stays 0.
